ncc_peak_tracker: RTL and testbench
===================================

Name: ncc_peak_tracker

Overview:
- Sits directly downstream of the 16x16 NCC processing-element array.
- For each window position, consumes the 16 per-row 8-bit signed accumulator outputs and reduces them to one signed correlation score.
- Tracks the maximum score over a raster scan of window positions.
- Reports the best-match (x, y) coordinate and score to the star-tracking controller through a valid/ready handshake.

Parameters:
- POS_X, 625, window positions per scan row (640-pixel window minus 15).
- POS_Y, 465, scan rows per search.
- XW, $clog2(POS_X), width of the x coordinate.
- YW, $clog2(POS_Y), width of the y coordinate.

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- start  in  1  one-cycle pulse that begins a search; honoured only in IDLE
- abort  in  1  synchronous cancel; returns to IDLE from any state
- acc_valid  in  1  acc_in holds the row sums for the next raster position
- acc_ready  out  1  high only in SCAN
- acc_in  in  16x8  per-row accumulator outputs, two's complement
- thresh  in  12  signed detection threshold, sampled at start
- res_valid  out  1  result available
- res_ready  in  1  consumer accepts the result
- best_x  out  XW  column of the best match
- best_y  out  YW  row of the best match
- best_score  out  12  signed best score
- found  out  1  best_score >= thresh latched at start

Behaviour:
- Reset: state=IDLE; acc_ready=0, res_valid=0, best_x=0, best_y=0, best_score=0, found=0; counters cleared.
- States:
  - IDLE -> SCAN on start. Clear counters and the first flag; latch thresh.
  - SCAN: accept a beat on each edge where acc_valid && acc_ready. The x counter increments and wraps at POS_X-1, incrementing y. The beat at x=POS_X-1, y=POS_Y-1 is the last beat: go to FLUSH.
  - FLUSH: one cycle; acc_ready=0; the final compare completes; go to DONE.
  - DONE: res_valid=1; outputs stable. On res_valid && res_ready, go to IDLE and clear res_valid on that edge.
- Pipeline stage 1, on an accepted beat:
  - Register the sign-extended sum of the 16 inputs as 12-bit signed (range -2048..2032; no overflow possible).
  - Register the beat's coordinate alongside the sum.
- Pipeline stage 2, one cycle after stage 1:
  - If the first flag is set or sum > best_score (strict, signed), load best_score, best_x and best_y; clear the first flag.
  - Ties keep the earlier position (raster order).
- found is combinational from registered best_score and the latched thresh; it is only meaningful while res_valid.
- Latency: the last beat is accepted at edge E. The state enters FLUSH at E and DONE at E+1; res_valid is visible after E+1.
- Bubbles (acc_valid low in SCAN) stall the counters and insert no compare.
- start in SCAN, FLUSH or DONE is ignored.
- acc_valid outside SCAN is ignored, with no counter change.
- abort beats start on the same edge. In any state it forces IDLE, clears res_valid and discards the in-flight pipeline stage. best_* keep their values, but DONE is not re-entered until a new search completes.
- res_ready outside DONE has no effect.
- Asynchronous rst mid-scan clears everything immediately. The next search requires a fresh start.
- Outputs must not change while res_valid=1 and res_ready=0.

Test Plan:
- Bench parameters: POS_X=4, POS_Y=3 (12 positions). All acc_in=0 except beat 7 (x=3, y=1) with every row=+5. Expect best_score=80, best_x=3, best_y=1. res_valid rises 2 edges after beat 11.
- All beats with every row=-128: best_score=-2048 (min-boundary sum) at (0,0). With thresh=-2048, found=1. Then a run with all rows=+127 gives 2032.
- Equal peak 40 at beats 2 and 9: reports (2,0) (first wins). Then insert random acc_valid bubbles: same result, and no extra beats are counted.
- Hold res_ready=0 for 10 cycles in DONE: outputs stable and start ignored. Pulse res_ready: IDLE next cycle, res_valid=0.
- abort at beat 6, then a new start with peak 30 at beat 1: result (1,0) score 30, with no contamination from the aborted run.
- Assert rst asynchronously mid-scan: all outputs 0 before the next clock edge. A subsequent full run produces the correct peak.

Source files
------------

// File: rtl/ncc_peak_tracker.sv
// ---------------------------------------------------------------------------
// ncc_peak_tracker
//
// Reduces the 16 per-row signed accumulator outputs of the NCC PE array to a
// single 12-bit signed correlation score per window position, tracks the
// maximum score over a raster scan of POS_X x POS_Y positions, and hands the
// best-match coordinate and score to the star-tracking controller.
//
// Ports
//   clk         clock
//   rst         asynchronous, active-high reset
//   start       one-cycle pulse, begins a search (IDLE only)
//   abort       synchronous cancel back to IDLE from any state
//   acc_valid   acc_in carries the row sums of the next raster position
//   acc_ready   high while scanning
//   acc_in      16 x 8-bit two's-complement row sums
//   thresh      signed detection threshold, captured on start
//   res_valid   result available (held until res_ready)
//   res_ready   consumer accepts the result
//   best_x      column of the best match
//   best_y      row of the best match
//   best_score  signed best score
//   found       best_score >= captured threshold, qualified by res_valid
// ---------------------------------------------------------------------------
module ncc_peak_tracker #(
    parameter int POS_X = 625,
    parameter int POS_Y = 465,
    parameter int XW    = $clog2(POS_X),
    parameter int YW    = $clog2(POS_Y)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic                abort,
    input  logic                acc_valid,
    output logic                acc_ready,
    input  logic [15:0][7:0]    acc_in,
    input  logic signed [11:0]  thresh,
    output logic                res_valid,
    input  logic                res_ready,
    output logic [XW-1:0]       best_x,
    output logic [YW-1:0]       best_y,
    output logic signed [11:0]  best_score,
    output logic                found
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SCAN  = 2'd1,
        ST_FLUSH = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    // Sign-extend each 8-bit row sum to 12 bits and add them. 16 * [-128,127]
    // spans [-2048,2032], which always fits, so no saturation is needed.
    function automatic logic signed [11:0] sum_rows(input logic [15:0][7:0] rows);
        logic signed [11:0] acc;
        acc = 12'sd0;
        for (int i = 0; i < 16; i++) begin
            acc = acc + {{4{rows[i][7]}}, rows[i]};
        end
        return acc;
    endfunction

    state_t                state_r;
    state_t                state_nx;

    logic                  acc_ready_r;
    logic                  res_valid_r;

    logic [XW-1:0]         x_r;
    logic [YW-1:0]         y_r;
    logic                  first_r;
    logic signed [11:0]    thresh_r;

    logic                  s1_valid_r;
    logic signed [11:0]    s1_sum_r;
    logic [XW-1:0]         s1_x_r;
    logic [YW-1:0]         s1_y_r;

    logic [XW-1:0]         best_x_r;
    logic [YW-1:0]         best_y_r;
    logic signed [11:0]    best_score_r;

    logic                  start_go_s;
    logic                  accept_s;
    logic                  x_wrap_s;
    logic                  last_beat_s;
    logic                  update_s;

    // A start only counts in IDLE, and abort wins over it on the same edge.
    assign start_go_s  = (state_r == ST_IDLE) && start && !abort;
    // A beat is taken only while scanning; abort drops the beat offered with it.
    assign accept_s    = (state_r == ST_SCAN) && acc_ready_r && acc_valid && !abort;
    assign x_wrap_s    = (x_r == XW'(POS_X - 1));
    assign last_beat_s = accept_s && x_wrap_s && (y_r == YW'(POS_Y - 1));
    // Strict compare keeps the earliest position on ties (raster order).
    assign update_s    = s1_valid_r && !abort && (first_r || (s1_sum_r > best_score_r));

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nx;
        end
    end

    // Next-state decode; abort returns to IDLE from every state.
    always_comb begin
        state_nx = state_r;
        if (abort) begin
            state_nx = ST_IDLE;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (start) begin
                        state_nx = ST_SCAN;
                    end else begin
                        state_nx = ST_IDLE;
                    end
                end
                ST_SCAN: begin
                    if (last_beat_s) begin
                        state_nx = ST_FLUSH;
                    end else begin
                        state_nx = ST_SCAN;
                    end
                end
                ST_FLUSH: begin
                    state_nx = ST_DONE;
                end
                ST_DONE: begin
                    if (res_valid_r && res_ready) begin
                        state_nx = ST_IDLE;
                    end else begin
                        state_nx = ST_DONE;
                    end
                end
                default: begin
                    state_nx = ST_IDLE;
                end
            endcase
        end
    end

    // Handshake flags are registered copies of the next-state decode so they
    // track the state exactly without a combinational path to the outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc_ready_r <= 1'b0;
            res_valid_r <= 1'b0;
        end else begin
            acc_ready_r <= (state_nx == ST_SCAN);
            res_valid_r <= (state_nx == ST_DONE);
        end
    end

    // Raster position counters and per-search threshold capture.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            x_r      <= {XW{1'b0}};
            y_r      <= {YW{1'b0}};
            thresh_r <= 12'sd0;
        end else if (abort) begin
            x_r      <= {XW{1'b0}};
            y_r      <= {YW{1'b0}};
            thresh_r <= thresh_r;
        end else if (start_go_s) begin
            x_r      <= {XW{1'b0}};
            y_r      <= {YW{1'b0}};
            thresh_r <= thresh;
        end else if (accept_s) begin
            thresh_r <= thresh_r;
            if (x_wrap_s) begin
                x_r <= {XW{1'b0}};
                y_r <= y_r + YW'(1);
            end else begin
                x_r <= x_r + XW'(1);
                y_r <= y_r;
            end
        end else begin
            x_r      <= x_r;
            y_r      <= y_r;
            thresh_r <= thresh_r;
        end
    end

    // Pipeline stage 1: row reduction plus the coordinate of that beat.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid_r <= 1'b0;
            s1_sum_r   <= 12'sd0;
            s1_x_r     <= {XW{1'b0}};
            s1_y_r     <= {YW{1'b0}};
        end else if (accept_s) begin
            s1_valid_r <= 1'b1;
            s1_sum_r   <= sum_rows(acc_in);
            s1_x_r     <= x_r;
            s1_y_r     <= y_r;
        end else begin
            s1_valid_r <= 1'b0;
            s1_sum_r   <= s1_sum_r;
            s1_x_r     <= s1_x_r;
            s1_y_r     <= s1_y_r;
        end
    end

    // Pipeline stage 2: running maximum. The first flag forces the first beat
    // of a search to load, so results of earlier searches never leak in.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            first_r      <= 1'b0;
            best_x_r     <= {XW{1'b0}};
            best_y_r     <= {YW{1'b0}};
            best_score_r <= 12'sd0;
        end else if (start_go_s) begin
            first_r      <= 1'b1;
            best_x_r     <= best_x_r;
            best_y_r     <= best_y_r;
            best_score_r <= best_score_r;
        end else if (update_s) begin
            first_r      <= 1'b0;
            best_x_r     <= s1_x_r;
            best_y_r     <= s1_y_r;
            best_score_r <= s1_sum_r;
        end else begin
            first_r      <= first_r;
            best_x_r     <= best_x_r;
            best_y_r     <= best_y_r;
            best_score_r <= best_score_r;
        end
    end

    assign acc_ready  = acc_ready_r;
    assign res_valid  = res_valid_r;
    assign best_x     = best_x_r;
    assign best_y     = best_y_r;
    assign best_score = best_score_r;
    // Qualified by res_valid so it reads 0 out of reset and while idle.
    assign found      = res_valid_r && (best_score_r >= thresh_r);

endmodule

// File: tb/tb_ncc_peak_tracker.sv
// ---------------------------------------------------------------------------
// tb_ncc_peak_tracker
//
// Directed bench for ncc_peak_tracker with a 4 x 3 raster (12 beats).
// Beat i sits at x = i % 4, y = i / 4. Each scenario task drives its stimulus
// and compares the DUT outputs against hand-computed constants.
// ---------------------------------------------------------------------------
module tb_ncc_peak_tracker;

    logic                clk;
    logic                rst;
    logic                start;
    logic                abort;
    logic                acc_valid;
    logic                acc_ready;
    logic [15:0][7:0]    acc_in;
    logic signed [11:0]  thresh;
    logic                res_valid;
    logic                res_ready;
    logic [1:0]          best_x;
    logic [1:0]          best_y;
    logic signed [11:0]  best_score;
    logic                found;

    int n_cmp;
    int n_bad;

    logic [15:0][7:0] beat_vec [12];

    ncc_peak_tracker #(.POS_X(4), .POS_Y(3)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .abort      (abort),
        .acc_valid  (acc_valid),
        .acc_ready  (acc_ready),
        .acc_in     (acc_in),
        .thresh     (thresh),
        .res_valid  (res_valid),
        .res_ready  (res_ready),
        .best_x     (best_x),
        .best_y     (best_y),
        .best_score (best_score),
        .found      (found)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_beats();
        for (int i = 0; i < 12; i++) beat_vec[i] = 128'd0;
    endtask

    // Put value v into rows 0..nrows-1 of beat idx.
    task automatic set_beat(input int idx, input int nrows, input logic [7:0] v);
        for (int r = 0; r < nrows; r++) beat_vec[idx][r] = v;
    endtask

    task automatic start_search(input logic signed [11:0] th);
        thresh = th;
        start  = 1'b1;
        tick();
        start  = 1'b0;
    endtask

    // Feed beats first..last; a set bit in bubbles inserts one idle cycle first.
    task automatic feed(input int first, input int last, input logic [11:0] bubbles);
        for (int i = first; i <= last; i++) begin
            if (bubbles[i]) begin
                acc_valid = 1'b0;
                acc_in    = {8{16'hA5C3}};
                tick();
            end
            acc_valid = 1'b1;
            acc_in    = beat_vec[i];
            tick();
        end
        acc_valid = 1'b0;
        acc_in    = 128'd0;
    endtask

    // Full scan followed by the FLUSH/DONE latency checks.
    task automatic full_run(input string name, input logic signed [11:0] th,
                            input logic [11:0] bubbles);
        start_search(th);
        feed(0, 11, bubbles);
        n_cmp++;
        if ({res_valid, acc_ready} !== 2'b00) begin
            n_bad++;
            $display("FAIL %s_flush: got rv/ar=%b want 00", name, {res_valid, acc_ready});
        end
        tick();
        n_cmp++;
        if (res_valid !== 1'b1) begin
            n_bad++;
            $display("FAIL %s_done: got res_valid=%b want 1", name, res_valid);
        end
    endtask

    task automatic take_result(input string name);
        res_ready = 1'b1;
        tick();
        res_ready = 1'b0;
        n_cmp++;
        if ({res_valid, found} !== 2'b00) begin
            n_bad++;
            $display("FAIL %s_take: got rv/found=%b want 00", name, {res_valid, found});
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        #2;
        n_cmp++;
        if ({acc_ready, res_valid, best_x, best_y, best_score, found} !== 18'd0) begin
            n_bad++;
            $display("FAIL reset_outputs: got %h want 0",
                     {acc_ready, res_valid, best_x, best_y, best_score, found});
        end
        tick();
        tick();
        rst = 1'b0;
        tick();
        n_cmp++;
        if ({acc_ready, res_valid} !== 2'b00) begin
            n_bad++;
            $display("FAIL reset_idle: got %b want 00", {acc_ready, res_valid});
        end
    endtask

    task automatic test_single_peak();
        clear_beats();
        set_beat(7, 16, 8'sd5);
        full_run("peak", 12'sd0, 12'b0);
        n_cmp++;
        if ({best_x, best_y, best_score, found} !== {2'd3, 2'd1, 12'd80, 1'b1}) begin
            n_bad++;
            $display("FAIL peak_result: got x=%0d y=%0d s=%0d f=%b want x=3 y=1 s=80 f=1",
                     best_x, best_y, best_score, found);
        end
        take_result("peak");
    endtask

    task automatic test_min_max();
        clear_beats();
        for (int i = 0; i < 12; i++) set_beat(i, 16, 8'h80);
        full_run("min", -12'sd2048, 12'b0);
        n_cmp++;
        if ({best_x, best_y, best_score, found} !== {2'd0, 2'd0, 12'h800, 1'b1}) begin
            n_bad++;
            $display("FAIL min_result: got x=%0d y=%0d s=%0d f=%b want x=0 y=0 s=-2048 f=1",
                     best_x, best_y, best_score, found);
        end
        take_result("min");
        clear_beats();
        for (int i = 0; i < 12; i++) set_beat(i, 16, 8'h7F);
        full_run("max", 12'sd2032, 12'b0);
        n_cmp++;
        if ({best_x, best_y, best_score, found} !== {2'd0, 2'd0, 12'h7F0, 1'b1}) begin
            n_bad++;
            $display("FAIL max_result: got x=%0d y=%0d s=%0d f=%b want x=0 y=0 s=2032 f=1",
                     best_x, best_y, best_score, found);
        end
        take_result("max");
    endtask

    task automatic test_tie();
        clear_beats();
        set_beat(2, 8, 8'sd5);
        set_beat(9, 8, 8'sd5);
        full_run("tie", 12'sd41, 12'b0);
        n_cmp++;
        if ({best_x, best_y, best_score, found} !== {2'd2, 2'd0, 12'd40, 1'b0}) begin
            n_bad++;
            $display("FAIL tie_result: got x=%0d y=%0d s=%0d f=%b want x=2 y=0 s=40 f=0",
                     best_x, best_y, best_score, found);
        end
        take_result("tie");
    endtask

    // Same tie data with bubbles; the result is left pending for test_hold_done.
    task automatic test_bubbles();
        full_run("bubble", 12'sd40, 12'b1010_0110_0101);
        n_cmp++;
        if ({best_x, best_y, best_score, found} !== {2'd2, 2'd0, 12'd40, 1'b1}) begin
            n_bad++;
            $display("FAIL bubble_result: got x=%0d y=%0d s=%0d f=%b want x=2 y=0 s=40 f=1",
                     best_x, best_y, best_score, found);
        end
    endtask

    task automatic test_hold_done();
        res_ready = 1'b0;
        for (int c = 0; c < 10; c++) begin
            start  = (c == 3) ? 1'b1 : 1'b0;
            thresh = 12'sd2000;
            tick();
            start  = 1'b0;
            n_cmp++;
            if ({res_valid, acc_ready, best_x, best_y, best_score, found} !==
                {1'b1, 1'b0, 2'd2, 2'd0, 12'd40, 1'b1}) begin
                n_bad++;
                $display("FAIL hold_cycle%0d: got rv=%b ar=%b x=%0d y=%0d s=%0d f=%b",
                         c, res_valid, acc_ready, best_x, best_y, best_score, found);
            end
        end
        take_result("hold");
        tick();
        n_cmp++;
        if (acc_ready !== 1'b0) begin
            n_bad++;
            $display("FAIL hold_idle: got acc_ready=%b want 0", acc_ready);
        end
    endtask

    task automatic test_abort();
        // abort together with start in IDLE: stays idle
        start = 1'b1;
        abort = 1'b1;
        tick();
        start = 1'b0;
        abort = 1'b0;
        n_cmp++;
        if (acc_ready !== 1'b0) begin
            n_bad++;
            $display("FAIL abort_start: got acc_ready=%b want 0", acc_ready);
        end
        clear_beats();
        set_beat(3, 10, 8'sd10);
        set_beat(5, 16, 8'h7F);
        start_search(12'sd0);
        feed(0, 5, 12'b0);
        acc_valid = 1'b1;
        acc_in    = {16{8'h7F}};
        abort     = 1'b1;
        tick();
        abort     = 1'b0;
        acc_valid = 1'b0;
        n_cmp++;
        if ({acc_ready, res_valid, best_x, best_y, best_score} !==
            {1'b0, 1'b0, 2'd3, 2'd0, 12'd100}) begin
            n_bad++;
            $display("FAIL abort_state: got ar=%b rv=%b x=%0d y=%0d s=%0d want ar=0 rv=0 x=3 y=0 s=100",
                     acc_ready, res_valid, best_x, best_y, best_score);
        end
        clear_beats();
        set_beat(1, 6, 8'sd5);
        full_run("post_abort", 12'sd0, 12'b0);
        n_cmp++;
        if ({best_x, best_y, best_score, found} !== {2'd1, 2'd0, 12'd30, 1'b1}) begin
            n_bad++;
            $display("FAIL post_abort_result: got x=%0d y=%0d s=%0d f=%b want x=1 y=0 s=30 f=1",
                     best_x, best_y, best_score, found);
        end
        take_result("post_abort");
    endtask

    task automatic test_async_reset();
        clear_beats();
        set_beat(2, 12, 8'sd9);
        start_search(12'sd0);
        feed(0, 4, 12'b0);
        n_cmp++;
        if (best_score !== 12'sd108) begin
            n_bad++;
            $display("FAIL pre_rst_score: got %0d want 108", best_score);
        end
        #2;
        rst = 1'b1;
        #1;
        n_cmp++;
        if ({acc_ready, res_valid, best_x, best_y, best_score, found} !== 18'd0) begin
            n_bad++;
            $display("FAIL async_rst: got %h want 0",
                     {acc_ready, res_valid, best_x, best_y, best_score, found});
        end
        tick();
        rst = 1'b0;
        tick();
        n_cmp++;
        if (acc_ready !== 1'b0) begin
            n_bad++;
            $display("FAIL rst_needs_start: got acc_ready=%b want 0", acc_ready);
        end
        clear_beats();
        set_beat(10, 12, 8'sd5);
        full_run("post_rst", 12'sd61, 12'b0);
        n_cmp++;
        if ({best_x, best_y, best_score, found} !== {2'd2, 2'd2, 12'd60, 1'b0}) begin
            n_bad++;
            $display("FAIL post_rst_result: got x=%0d y=%0d s=%0d f=%b want x=2 y=2 s=60 f=0",
                     best_x, best_y, best_score, found);
        end
        take_result("post_rst");
    endtask

    initial begin
        n_cmp     = 0;
        n_bad     = 0;
        rst       = 1'b1;
        start     = 1'b0;
        abort     = 1'b0;
        acc_valid = 1'b0;
        acc_in    = 128'd0;
        thresh    = 12'sd0;
        res_ready = 1'b0;
        clear_beats();

        test_reset();
        test_single_peak();
        test_min_max();
        test_tie();
        test_bubbles();
        test_hold_done();
        test_abort();
        test_async_reset();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
